// File: rtl/observer_accel_reader.sv
// SPI mode-3 master for a LIS3DH-style accelerometer: one config write after
// reset, then periodic X/Y/Z burst reads handed off over valid/ready.
module observer_accel_reader #(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 32000,
    parameter logic [7:0] CFG_VAL       = 8'h77
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic        o_sclk,
    output logic        o_cs_n,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic [15:0] o_z,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overrun,
    output logic        o_busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [5:0] CFG_LAST_BIT = 6'd15;
    localparam logic [5:0] RD_LAST_BIT  = 6'd55;
    localparam logic [55:0] CFG_WORD = {8'h20, CFG_VAL, 40'h0};
    localparam logic [55:0] RD_WORD  = {8'hE8, 48'h0};

    typedef enum logic [1:0] {
        S_IDLE_CFG,
        S_CFG,
        S_WAIT,
        S_RD
    } state_e;

    typedef enum logic [1:0] {
        P_SETUP,
        P_LOW,
        P_HIGH,
        P_HOLD
    } phase_e;

    state_e state_q, state_d;
    phase_e phase_q, phase_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic [55:0]      tx_q, tx_d;
    logic [47:0]      rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfg_done_q, cfg_done_d;
    logic             rd_done_q, rd_done_d;
    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    logic [15:0]      z_q, z_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic       in_frame;
    logic       div_end;
    logic [5:0] last_bit;
    logic       frame_done;
    logic       start_cfg;
    logic       start_rd;

    always_comb begin
        in_frame   = (state_q == S_CFG) || (state_q == S_RD);
        div_end    = (div_q == DIV_LAST);
        last_bit   = (state_q == S_CFG) ? CFG_LAST_BIT : RD_LAST_BIT;
        frame_done = in_frame && (phase_q == P_HOLD) && div_end;
        start_cfg  = (state_q == S_IDLE_CFG) && i_en;
        start_rd   = (state_q == S_WAIT) && i_en && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE_CFG: if (i_en) state_d = S_CFG;
            S_CFG:      if (frame_done) state_d = S_WAIT;
            S_WAIT:     if (start_rd) state_d = S_RD;
            S_RD:       if (frame_done) state_d = S_WAIT;
        endcase
    end

    // SPI bit engine: each phase lasts CLK_DIV clocks, edges land on div_end
    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        if (start_cfg || start_rd) begin
            cs_n_d  = 1'b0;
            sclk_d  = 1'b1;
            mosi_d  = 1'b0;
            phase_d = P_SETUP;
            div_d   = '0;
            bit_d   = '0;
            tx_d    = start_cfg ? CFG_WORD : RD_WORD;
        end else if (in_frame) begin
            div_d = div_end ? '0 : div_q + 1'b1;
            if (div_end) begin
                unique case (phase_q)
                    P_SETUP: begin
                        phase_d = P_LOW;
                        sclk_d  = 1'b0;
                        mosi_d  = tx_q[55];
                        tx_d    = {tx_q[54:0], 1'b0};
                    end
                    P_LOW: begin
                        phase_d = P_HIGH;
                        sclk_d  = 1'b1;
                        if (state_q == S_RD) begin
                            rx_d = {rx_q[46:0], i_miso};
                        end
                    end
                    P_HIGH: begin
                        if (bit_q == last_bit) begin
                            phase_d = P_HOLD;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            phase_d = P_LOW;
                            sclk_d  = 1'b0;
                            mosi_d  = tx_q[55];
                            tx_d    = {tx_q[54:0], 1'b0};
                        end
                    end
                    P_HOLD: begin
                        cs_n_d = 1'b1;
                        mosi_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!i_en) begin
            cnt_d = '0;
        end else if (cfg_done_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        cfg_done_d = cfg_done_q || ((state_q == S_CFG) && frame_done);
        rd_done_d  = (state_q == S_RD) && frame_done;
    end

    // rx_q keeps the last 48 bits: X_L,X_H,Y_L,Y_H,Z_L,Z_H from MSB down
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (rd_done_q) begin
            x_d       = {rx_q[39:32], rx_q[47:40]};
            y_d       = {rx_q[23:16], rx_q[31:24]};
            z_d       = {rx_q[7:0],   rx_q[15:8]};
            valid_d   = 1'b1;
            overrun_d = valid_q && !i_ready;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q    <= P_SETUP;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sclk_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            cnt_q      <= '0;
            cfg_done_q <= 1'b0;
            rd_done_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            cnt_q      <= cnt_d;
            cfg_done_q <= cfg_done_d;
            rd_done_q  <= rd_done_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_sclk    = sclk_q;
    assign o_cs_n    = cs_n_q;
    assign o_mosi    = mosi_q;
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_z       = z_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
    assign o_busy    = ~cs_n_q;

endmodule

// File: tb/tb_observer_accel_reader.sv
// Directed bench for observer_accel_reader with an SPI slave model and
// edge-timing monitor; CLK_DIV=4, SAMPLE_PERIOD=2000.
module tb_observer_accel_reader;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b1;
    logic        i_ready = 1'b0;
    logic        i_miso = 1'b0;
    logic        o_sclk, o_cs_n, o_mosi, o_valid, o_overrun, o_busy;
    logic [15:0] o_x, o_y, o_z;

    observer_accel_reader #(
        .CLK_DIV(4),
        .SAMPLE_PERIOD(2000),
        .CFG_VAL(8'h77)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_en(i_en),
        .o_sclk(o_sclk),
        .o_cs_n(o_cs_n),
        .o_mosi(o_mosi),
        .i_miso(i_miso),
        .o_x(o_x),
        .o_y(o_y),
        .o_z(o_z),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // SPI slave: logs MOSI on SCLK rise, shifts s_tx out on SCLK fall
    logic [47:0] s_data = 48'h0;
    logic [55:0] s_tx = 56'h0;
    logic [55:0] s_rx = 56'h0;
    int          s_bits = 0;
    logic        s_cs_p = 1'b1;
    logic        s_sclk_p = 1'b1;

    always @(o_cs_n or o_sclk) begin
        if (s_cs_p && !o_cs_n) begin
            s_bits = 0;
            s_rx   = 56'h0;
            s_tx   = {8'h00, s_data};
        end else if (!o_cs_n && !s_sclk_p && o_sclk) begin
            s_rx   = {s_rx[54:0], o_mosi};
            s_bits = s_bits + 1;
        end else if (!o_cs_n && s_sclk_p && !o_sclk) begin
            i_miso = s_tx[55];
            s_tx   = {s_tx[54:0], 1'b0};
        end
        s_cs_p   = o_cs_n;
        s_sclk_p = o_sclk;
    end

    // timing monitor on the inactive clock edge
    int   cyc = 0;
    int   fall_cyc = 0;
    int   fall_prev = 0;
    int   rise_cyc = 0;
    int   falls = 0;
    int   sclk_rise = 0;
    int   sclk_per = 0;
    int   ovr_cnt = 0;
    logic m_cs_p = 1'b1;
    logic m_sclk_p = 1'b1;

    always @(negedge i_clk) begin
        cyc = cyc + 1;
        if (m_cs_p && !o_cs_n) begin
            fall_prev = fall_cyc;
            fall_cyc  = cyc;
            falls     = falls + 1;
        end
        if (!m_cs_p && o_cs_n) rise_cyc = cyc;
        if (!m_sclk_p && o_sclk && !o_cs_n) begin
            sclk_per  = cyc - sclk_rise;
            sclk_rise = cyc;
        end
        if (o_overrun) ovr_cnt = ovr_cnt + 1;
        m_cs_p   = o_cs_n;
        m_sclk_p = o_sclk;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wait_cs(input logic lvl, input int budget,
                           input string tag);
        int n = 0;
        while (o_cs_n !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, {63'h0, o_cs_n}, {63'h0, lvl});
        #4;
    endtask

    int saved;

    initial begin
        // 1: reset values with i_en held high
        repeat (3) tick();
        check("rst_sclk", {63'h0, o_sclk}, 64'h1);
        check("rst_cs_n", {63'h0, o_cs_n}, 64'h1);
        check("rst_mosi", {63'h0, o_mosi}, 64'h0);
        check("rst_xyz", {16'h0, o_x, o_y, o_z}, 64'h0);
        check("rst_valid", {63'h0, o_valid}, 64'h0);
        check("rst_ovr", {63'h0, o_overrun}, 64'h0);
        check("rst_busy", {63'h0, o_busy}, 64'h0);
        i_rst_n = 1'b1;
        tick();
        check("first_cs_fall", {63'h0, o_cs_n}, 64'h0);
        check("busy_in_frame", {63'h0, o_busy}, 64'h1);

        // 2: config frame content and timing
        s_data = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wait_cs(1'b1, 300, "cfg_end");
        check("cfg_word", {48'h0, s_rx[15:0]}, 64'h2077);
        check("cfg_edges", 64'(s_bits), 64'd16);
        check("sclk_period", 64'(sclk_per), 64'd8);
        check("cfg_cs_low", 64'(rise_cyc - fall_cyc), 64'd136);

        // 3: first read frame
        wait_cs(1'b0, 2100, "rd1_start");
        check("rd1_delay", 64'(fall_cyc - rise_cyc), 64'd2000);
        wait_cs(1'b1, 600, "rd1_end");
        check("rd1_cmd", {8'h0, s_rx}, {8'h0, 8'hE8, 48'h0});
        check("rd1_edges", 64'(s_bits), 64'd56);
        check("rd1_cs_low", 64'(rise_cyc - fall_cyc), 64'd456);
        check("rd1_valid_lag", {63'h0, o_valid}, 64'h0);
        s_data = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        tick();
        check("rd1_x", {48'h0, o_x}, 64'h2211);
        check("rd1_y", {48'h0, o_y}, 64'h4433);
        check("rd1_z", {48'h0, o_z}, 64'h6655);
        check("rd1_valid", {63'h0, o_valid}, 64'h1);
        check("rd1_no_ovr", {63'h0, o_overrun}, 64'h0);

        // 4: unaccepted sample overwritten
        wait_cs(1'b0, 2100, "rd2_start");
        check("rd2_spacing", 64'(fall_cyc - fall_prev), 64'd2000);
        wait_cs(1'b1, 600, "rd2_end");
        tick();
        check("rd2_ovr", {63'h0, o_overrun}, 64'h1);
        check("rd2_xyz", {16'h0, o_x, o_y, o_z}, 64'h0000_BBAA_DDCC_FFEE);
        check("rd2_valid", {63'h0, o_valid}, 64'h1);
        tick();
        check("rd2_ovr_pulse", {63'h0, o_overrun}, 64'h0);
        check("rd2_valid_hold", {63'h0, o_valid}, 64'h1);
        i_ready = 1'b1;
        tick();
        check("accept_clear", {63'h0, o_valid}, 64'h0);
        i_ready = 1'b0;
        check("ovr_count", 64'(ovr_cnt), 64'd1);

        // 5: drop i_en mid-frame
        s_data = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        wait_cs(1'b0, 2100, "rd3_start");
        check("rd3_spacing", 64'(fall_cyc - fall_prev), 64'd2000);
        repeat (200) tick();
        i_en = 1'b0;
        wait_cs(1'b1, 400, "rd3_end");
        tick();
        check("rd3_xyz", {16'h0, o_x, o_y, o_z}, 64'h0000_0201_0403_0605);
        check("rd3_valid", {63'h0, o_valid}, 64'h1);
        saved = falls;
        repeat (2500) tick();
        check("en_off_quiet", 64'(falls - saved), 64'd0);
        check("en_off_cs", {63'h0, o_cs_n}, 64'h1);
        check("stable_x", {48'h0, o_x}, 64'h0201);
        check("stable_valid", {63'h0, o_valid}, 64'h1);
        check("ovr_count2", 64'(ovr_cnt), 64'd1);

        // 6: reset in the middle of a read frame
        i_en = 1'b1;
        wait_cs(1'b0, 2100, "rd4_start");
        saved = 0;
        while (s_bits < 20 && saved < 400) begin
            tick();
            saved++;
        end
        check("rd4_bit20", 64'(s_bits), 64'd20);
        i_rst_n = 1'b0;
        #1;
        check("abort_cs", {63'h0, o_cs_n}, 64'h1);
        check("abort_sclk", {63'h0, o_sclk}, 64'h1);
        check("abort_valid", {63'h0, o_valid}, 64'h0);
        tick();
        tick();
        i_rst_n = 1'b1;
        check("abort_x", {48'h0, o_x}, 64'h0);
        wait_cs(1'b0, 5, "recfg_start");
        wait_cs(1'b1, 300, "recfg_end");
        check("recfg_word", {48'h0, s_rx[15:0]}, 64'h2077);
        check("recfg_edges", 64'(s_bits), 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
